// File: rtl/mic_pkt_pkg.sv
// Shared MIC packet definitions: packet types, header field layout,
// responder FSM encodings and the response-header builder.
package mic_pkt_pkg;

  // Packet type field values
  localparam logic [1:0] PKT_READ  = 2'b00;
  localparam logic [1:0] PKT_WRITE = 2'b01;
  localparam logic [1:0] PKT_RDATA = 2'b10;
  localparam logic [1:0] PKT_WRACK = 2'b11;

  // Header field positions (LSB) and widths
  localparam int HDR_BE_LSB   = 56;
  localparam int HDR_BE_W     = 8;
  localparam int HDR_SRC_LSB  = 48;
  localparam int HDR_SRC_W    = 8;
  localparam int HDR_LEN_LSB  = 40;
  localparam int HDR_LEN_W    = 8;
  localparam int HDR_TYPE_LSB = 32;
  localparam int HDR_TYPE_W   = 2;
  localparam int HDR_ADDR_LSB = 3;
  localparam int HDR_ADDR_W   = 29;

  // Responder FSM states
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_DATA = 3'd1;
  localparam logic [2:0] ST_WR_ACK  = 3'd2;
  localparam logic [2:0] ST_RD_HDR  = 3'd3;
  localparam logic [2:0] ST_RD_DATA = 3'd4;
  localparam logic [2:0] ST_DRAIN   = 3'd5;

  // Response header: strobes zeroed, src_id/rd_len echoed, word address kept in full.
  function automatic logic [63:0] build_rsp_hdr(input logic [7:0]  src_id,
                                                input logic [7:0]  rd_len,
                                                input logic [1:0]  typ,
                                                input logic [28:0] word_addr);
    return {8'h00, src_id, rd_len, 6'h00, typ, word_addr, 3'b000};
  endfunction

endpackage

// File: rtl/mic_bram_ram.sv
// Synchronous-read 64-bit RAM with per-byte write enables, written in the
// simple single-clock form that maps onto block RAM.
module mic_bram_ram #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [7:0]           be,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [63:0]          wdata,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [63:0]          rdata
);

  logic [63:0] mem [0:(1<<ADDR_BITS)-1];

  // Byte-lane writes and registered read; contents have no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 8; b++) begin
        if (be[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mic_bram_responder.sv
// MIC completer backed by on-chip RAM. Serves one READ or WRITE packet at a
// time and answers with an RDATA burst or a single-beat WRACK.
//
// Handshakes: both streams are AXI-Stream style. A beat transfers on a rising
// edge where VALID and READY are both high; the source never withdraws VALID
// or changes DATA/LAST until that transfer, and READY may toggle freely.
module mic_bram_responder
  import mic_pkt_pkg::*;
#(
  parameter int ADDR_BITS            = 10,
  parameter int RDATA_ALWAYS_ONES_BE = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        I_TVALID,
  output logic        I_TREADY,
  input  logic [63:0] I_TDATA,
  input  logic        I_TLAST,
  output logic        O_TVALID,
  input  logic        O_TREADY,
  output logic [63:0] O_TDATA,
  output logic        O_TLAST,
  output logic        err_bad_type,
  output logic [2:0]  dbg_state
);

  logic [2:0]           state, ret_state;
  logic [7:0]           src_id, rd_len, hdr_be;
  logic [28:0]          hdr_addr;
  logic [ADDR_BITS-1:0] idx;
  logic [8:0]           issued_cnt, sent_cnt;

  logic                 in_flight;
  logic [63:0]          fifo_mem [0:1];
  logic                 fifo_wr_ptr, fifo_rd_ptr;
  logic [1:0]           fifo_count;
  logic [2:0]           occ_after;

  logic                 ram_we, rd_issue, pop;
  logic [7:0]           ram_be;
  logic [63:0]          ram_rdata;
  logic [1:0]           in_type;

  assign in_type   = I_TDATA[HDR_TYPE_LSB +: HDR_TYPE_W];
  assign dbg_state = state;
  assign I_TREADY  = (state == ST_IDLE) || (state == ST_WR_DATA) || (state == ST_DRAIN);
  assign ram_we    = (state == ST_WR_DATA) && I_TVALID;
  assign ram_be    = (RDATA_ALWAYS_ONES_BE != 0) ? 8'hFF : hdr_be;
  assign pop       = (state == ST_RD_DATA) && (fifo_count != 2'd0) && O_TREADY;

  // Occupancy after this cycle's pop; a read may issue while it stays below 2,
  // which keeps the FIFO full-rate without ever overrunning under backpressure.
  assign occ_after = {1'b0, fifo_count} + {2'b00, in_flight} - {2'b00, pop};
  assign rd_issue  = ((state == ST_RD_HDR) || (state == ST_RD_DATA)) &&
                     (issued_cnt <= {1'b0, rd_len}) && (occ_after < 3'd2);

  mic_bram_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (ram_be),
    .waddr (idx),
    .wdata (I_TDATA),
    .re    (rd_issue),
    .raddr (idx),
    .rdata (ram_rdata)
  );

  // Packet FSM: header capture, write/read index walking and beat counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      ret_state    <= ST_IDLE;
      src_id       <= 8'h00;
      rd_len       <= 8'h00;
      hdr_be       <= 8'h00;
      hdr_addr     <= '0;
      idx          <= '0;
      issued_cnt   <= '0;
      sent_cnt     <= '0;
      err_bad_type <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (I_TVALID) begin
            hdr_be     <= I_TDATA[HDR_BE_LSB +: HDR_BE_W];
            src_id     <= I_TDATA[HDR_SRC_LSB +: HDR_SRC_W];
            rd_len     <= I_TDATA[HDR_LEN_LSB +: HDR_LEN_W];
            hdr_addr   <= I_TDATA[HDR_ADDR_LSB +: HDR_ADDR_W];
            idx        <= I_TDATA[HDR_ADDR_LSB +: ADDR_BITS];
            issued_cnt <= '0;
            sent_cnt   <= '0;
            case (in_type)
              PKT_READ: begin
                if (I_TLAST) begin
                  state <= ST_RD_HDR;
                end else begin
                  state     <= ST_DRAIN;
                  ret_state <= ST_RD_HDR;
                end
              end
              PKT_WRITE: state <= I_TLAST ? ST_WR_ACK : ST_WR_DATA;
              default: begin
                err_bad_type <= 1'b1;
                if (!I_TLAST) begin
                  state     <= ST_DRAIN;
                  ret_state <= ST_IDLE;
                end
              end
            endcase
          end
        end
        ST_WR_DATA: begin
          if (I_TVALID) begin
            idx <= idx + 1'b1;
            if (I_TLAST) state <= ST_WR_ACK;
          end
        end
        ST_WR_ACK:  if (O_TREADY) state <= ST_IDLE;
        ST_RD_HDR:  if (O_TREADY) state <= ST_RD_DATA;
        ST_RD_DATA: if (pop && (sent_cnt == {1'b0, rd_len})) state <= ST_IDLE;
        ST_DRAIN:   if (I_TVALID && I_TLAST) state <= ret_state;
        default:    state <= ST_IDLE;
      endcase
      if (rd_issue) begin
        idx        <= idx + 1'b1;
        issued_cnt <= issued_cnt + 9'd1;
      end
      if (pop) sent_cnt <= sent_cnt + 9'd1;
    end
  end

  // Tracks the read issued last cycle whose data is on ram_rdata now.
  always_ff @(posedge clk) begin
    if (reset) in_flight <= 1'b0;
    else       in_flight <= rd_issue;
  end

  // Output FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_wr_ptr <= 1'b0;
      fifo_rd_ptr <= 1'b0;
      fifo_count  <= 2'd0;
    end else begin
      if (in_flight) fifo_wr_ptr <= ~fifo_wr_ptr;
      if (pop)       fifo_rd_ptr <= ~fifo_rd_ptr;
      fifo_count <= fifo_count + {1'b0, in_flight} - {1'b0, pop};
    end
  end

  // Output FIFO storage, captured as RAM data returns.
  always_ff @(posedge clk) begin
    if (in_flight) fifo_mem[fifo_wr_ptr] <= ram_rdata;
  end

  // Response stream drive; values only change on a transfer or a state change.
  always_comb begin
    O_TVALID = 1'b0;
    O_TLAST  = 1'b0;
    O_TDATA  = 64'h0;
    case (state)
      ST_WR_ACK: begin
        O_TVALID = 1'b1;
        O_TLAST  = 1'b1;
        O_TDATA  = build_rsp_hdr(src_id, rd_len, PKT_WRACK, hdr_addr);
      end
      ST_RD_HDR: begin
        O_TVALID = 1'b1;
        O_TDATA  = build_rsp_hdr(src_id, rd_len, PKT_RDATA, hdr_addr);
      end
      ST_RD_DATA: begin
        if (fifo_count != 2'd0) begin
          O_TVALID = 1'b1;
          O_TLAST  = (sent_cnt == {1'b0, rd_len});
          O_TDATA  = fifo_mem[fifo_rd_ptr];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mic_bram_responder.sv
// Randomised scoreboard bench for mic_bram_responder: a behavioural RAM model
// predicts every response beat; a negedge monitor checks beats, ordering and
// hold-while-stalled.
module tb_mic_bram_responder;
  import mic_pkt_pkg::*;

  localparam int DEPTH = 1024;

  logic        clk, reset;
  logic        I_TVALID, I_TREADY, I_TLAST;
  logic [63:0] I_TDATA;
  logic        O_TVALID, O_TREADY, O_TLAST;
  logic [63:0] O_TDATA;
  logic        err_bad_type;
  logic [2:0]  dbg_state;

  mic_bram_responder #(.ADDR_BITS(10), .RDATA_ALWAYS_ONES_BE(0)) dut (
    .clk          (clk),
    .reset        (reset),
    .I_TVALID     (I_TVALID),
    .I_TREADY     (I_TREADY),
    .I_TDATA      (I_TDATA),
    .I_TLAST      (I_TLAST),
    .O_TVALID     (O_TVALID),
    .O_TREADY     (O_TREADY),
    .O_TDATA      (O_TDATA),
    .O_TLAST      (O_TLAST),
    .err_bad_type (err_bad_type),
    .dbg_state    (dbg_state)
  );

  int          n_vec = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          hs_count = 0;
  bit          bp_mode = 0;
  logic [63:0] exp_q[$];
  logic        exp_last_q[$];
  int          hs_cyc_q[$];
  logic [63:0] wr_beats[$];
  logic [63:0] ref_mem [DEPTH];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Downstream ready: always 1, or random when backpressure is enabled.
  initial begin
    O_TREADY = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      O_TREADY = bp_mode ? ($urandom_range(0, 99) < 55) : 1'b1;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic        stall_prev;
    logic [63:0] prev_data;
    logic        prev_last;
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check64("hold_valid", {63'h0, O_TVALID}, 64'h1);
          check64("hold_data", O_TDATA, prev_data);
          check64("hold_last", {63'h0, O_TLAST}, {63'h0, prev_last});
        end
        if (O_TVALID && O_TREADY) begin
          hs_count++;
          hs_cyc_q.push_back(cyc);
          if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_beat: got %h, expected no response", O_TDATA);
          end else begin
            check64("rsp_data", O_TDATA, exp_q.pop_front());
            check64("rsp_last", {63'h0, O_TLAST}, {63'h0, exp_last_q.pop_front()});
          end
        end
        stall_prev = O_TVALID && !O_TREADY;
        prev_data  = O_TDATA;
        prev_last  = O_TLAST;
      end
    end
  end

  // ---------------- model ----------------
  function automatic int word_of(input logic [31:0] addr, input int i);
    return (int'(addr >> 3) + i) % DEPTH;
  endfunction

  function automatic logic [63:0] req_hdr(input logic [7:0] be, input logic [7:0] src,
                                          input logic [7:0] len, input logic [1:0] typ,
                                          input logic [31:0] addr);
    return {be, src, len, 6'h00, typ, addr[31:3], 3'b000};
  endfunction

  // ---------------- drivers ----------------
  task automatic send_beat(input logic [63:0] d, input logic l);
    bit ok;
    ok = 0;
    I_TVALID = 1'b1;
    I_TDATA  = d;
    I_TLAST  = l;
    for (int c = 0; c < 3000 && !ok; c++) begin
      @(negedge clk);
      ok = I_TREADY;
      @(posedge clk);
      #1;
    end
    I_TVALID = 1'b0;
    I_TLAST  = 1'b0;
    n_vec++;
    if (!ok) begin
      n_fail++;
      $display("FAIL req_accept: I_TREADY stayed 0, expected 1");
    end
  endtask

  // WRITE using the beats queued in wr_beats (empty queue = header-only write).
  task automatic do_write(input logic [31:0] addr, input logic [7:0] be,
                          input logic [7:0] src, input logic [7:0] lenf);
    int n;
    logic [63:0] d;
    n = wr_beats.size();
    exp_q.push_back({8'h00, src, lenf, 6'h00, 2'b11, addr[31:3], 3'b000});
    exp_last_q.push_back(1'b1);
    send_beat(req_hdr(be, src, lenf, 2'b01, addr), n == 0);
    for (int i = 0; i < n; i++) begin
      d = wr_beats.pop_front();
      for (int b = 0; b < 8; b++)
        if (be[b]) ref_mem[word_of(addr, i)][8*b +: 8] = d[8*b +: 8];
      send_beat(d, i == n - 1);
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                         input logic [7:0] src, input int extra);
    exp_q.push_back({8'h00, src, len, 6'h00, 2'b10, addr[31:3], 3'b000});
    exp_last_q.push_back(1'b0);
    for (int i = 0; i <= int'(len); i++) begin
      exp_q.push_back(ref_mem[word_of(addr, i)]);
      exp_last_q.push_back(i == int'(len));
    end
    send_beat(req_hdr(8'h00, src, len, 2'b00, addr), extra == 0);
    for (int i = 0; i < extra; i++)
      send_beat({$urandom, $urandom}, i == extra - 1);
  endtask

  task automatic do_bad(input logic [1:0] typ, input int extra);
    send_beat(req_hdr(8'hFF, 8'h5A, 8'h00, typ, 32'h0000_0040), extra == 0);
    for (int i = 0; i < extra; i++)
      send_beat({$urandom, $urandom}, i == extra - 1);
  endtask

  task automatic wait_done();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 6000) begin
      @(posedge clk);
      c++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL rsp_timeout: %0d beats outstanding, expected 0", exp_q.size());
      exp_q.delete();
      exp_last_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int base, c;
    logic [31:0] a;
    reset    = 1'b1;
    I_TVALID = 1'b0;
    I_TDATA  = 64'h0;
    I_TLAST  = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check64("rst_o_tvalid", {63'h0, O_TVALID}, 64'h0);
    check64("rst_o_tlast", {63'h0, O_TLAST}, 64'h0);
    check64("rst_o_tdata", O_TDATA, 64'h0);
    check64("rst_err", {63'h0, err_bad_type}, 64'h0);
    check64("rst_state", {61'h0, dbg_state}, {61'h0, ST_IDLE});
    check64("rst_i_tready", {63'h0, I_TREADY}, 64'h1);
    @(posedge clk);
    #1;

    // Fill the whole RAM so every later read has a defined value.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 256; i++) wr_beats.push_back({$urandom, $urandom});
      do_write(k * 2048, 8'hFF, 8'h01, 8'h00);
      wait_done();
    end

    // Basic write then gap-free read
    wr_beats = '{64'h11, 64'h22, 64'h33, 64'h44};
    do_write(32'h100, 8'hFF, 8'h3C, 8'h03);
    wait_done();
    hs_cyc_q.delete();
    do_read(32'h100, 8'd3, 8'h3C, 0);
    wait_done();
    check64("rd4_beats", hs_cyc_q.size(), 5);
    if (hs_cyc_q.size() == 5) begin
      check64("rd4_first_bubble", hs_cyc_q[1] - hs_cyc_q[0], 2);
      check64("rd4_no_gaps", hs_cyc_q[4] - hs_cyc_q[1], 3);
    end

    // Partial byte strobes
    wr_beats = '{64'hFFFF_FFFF_FFFF_FFFF};
    do_write(32'h200, 8'hFF, 8'h02, 8'h00);
    wait_done();
    wr_beats = '{64'h0};
    do_write(32'h200, 8'h0F, 8'h02, 8'h00);
    wait_done();
    do_read(32'h200, 8'd0, 8'h02, 0);
    wait_done();

    // Backpressured 8-beat read
    bp_mode = 1;
    do_read(32'h100, 8'd7, 8'h77, 0);
    wait_done();

    // Index wrap at the top of the RAM, with upper address bits set (aliasing)
    for (int i = 0; i < 3; i++) wr_beats.push_back({$urandom, $urandom});
    do_write(32'hABC0_1FF8, 8'hFF, 8'h10, 8'h00);
    wait_done();
    do_read(32'h0000_1FF8, 8'd2, 8'h11, 0);
    wait_done();

    // Inbound RDATA-type packet: consumed silently, sticky error
    bp_mode = 0;
    base = hs_count;
    do_bad(2'b10, 2);
    repeat (8) @(posedge clk);
    #1;
    check64("bad_no_rsp", hs_count, base);
    check64("bad_err_set", {63'h0, err_bad_type}, 64'h1);
    check64("bad_back_idle", {63'h0, I_TREADY}, 64'h1);
    do_read(32'h208, 8'd1, 8'h21, 0);
    wait_done();
    do_bad(2'b11, 0);
    do_read(32'h200, 8'd0, 8'h22, 0);
    wait_done();
    check64("bad_err_sticky", {63'h0, err_bad_type}, 64'h1);

    // Randomised mix: aliasing addresses, header-only writes, drained reads
    bp_mode = 1;
    for (int n = 0; n < 40; n++) begin
      a = {$urandom} & 32'hFFFF_FFF8;
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < $urandom_range(0, 8); i++) wr_beats.push_back({$urandom, $urandom});
        do_write(a, 8'($urandom), 8'($urandom), 8'($urandom));
      end else begin
        do_read(a, 8'($urandom_range(0, 15)), 8'($urandom),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      end
      wait_done();
    end

    // Longest burst: rd_len=255 returns 256 beats
    base = hs_count;
    do_read(32'h0000_0F00, 8'd255, 8'hEE, 0);
    wait_done();
    check64("len255_beats", hs_count - base, 257);

    // Reset in the middle of an RDATA burst
    bp_mode = 0;
    @(posedge clk);
    #1;
    base = hs_count;
    do_read(32'h100, 8'd7, 8'h44, 0);
    c = 0;
    while (hs_count < base + 2 && c < 200) begin
      @(posedge clk);
      c++;
    end
    #1;
    reset = 1'b1;
    exp_q.delete();
    exp_last_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check64("midrst_beats_seen", hs_count - base, 2);
    check64("midrst_o_tvalid", {63'h0, O_TVALID}, 64'h0);
    check64("midrst_state", {61'h0, dbg_state}, {61'h0, ST_IDLE});
    check64("midrst_err_clr", {63'h0, err_bad_type}, 64'h0);
    @(posedge clk);
    #1;
    do_read(32'h100, 8'd7, 8'h45, 0);
    wait_done();

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
